// File: rtl/if_fetch_pkg.sv
// Shared widths, constants, control-level encodings and FSM states for the IF stage.
// Also holds the next-PC helper so the wrap and branch rules are written once.
package if_fetch_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] PC_RESET = 16'h0000;
  localparam logic [WORD_W-1:0] NOP_INST = 16'h0800;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;
  localparam logic StallYes   = 1'b1;
  localparam logic StallNo    = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Taken branch wins; otherwise sequential, wrapping modulo 2^16.
  function automatic logic [ADDR_W-1:0] next_pc(
    input logic [ADDR_W-1:0] pc,
    input logic              branch_flag,
    input logic [ADDR_W-1:0] branch_target
  );
    logic [ADDR_W-1:0] seq_pc;
    seq_pc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    return branch_flag ? branch_target : seq_pc;
  endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter register: loads PC_RESET on reset, next PC on an advance edge.
// One-cycle update latency; holds value whenever advance is low.
module if_fetch_pc_reg
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc <= PC_RESET;
    end else if (advance) begin
      pc <= next_pc(pc, branch_flag, branch_target);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns PC, fetches over req/ack, presents if_pc/if_inst to IF/ID.
// Memory data reaches if_inst combinationally; wait states raise fetch_stall_req, stalls park data in ibuf.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              fetch_stall_req,
  output logic [ADDR_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_inst
);

  fetch_state_t      state;
  logic [WORD_W-1:0] ibuf;
  logic [ADDR_W-1:0] pc;
  logic              advance;

  // The PC moves only when an instruction is actually handed to IF/ID,
  // so a branch seen during a stall is not applied until the stall clears.
  always_comb begin
    advance = 1'b0;
    unique case (state)
      REQ:     advance = mem_ack && (stall == StallNo);
      HOLD:    advance = (stall == StallNo);
      default: advance = 1'b0;
    endcase
  end

  if_fetch_pc_reg u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .advance       (advance),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .pc            (pc)
  );

  // mem_req is registered alongside the state so it is glitch-free to memory.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state   <= IDLE;
      ibuf    <= NOP_INST;
      mem_req <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
        REQ: begin
          if (mem_ack && (stall == StallYes)) begin
            ibuf    <= mem_rdata;
            state   <= HOLD;
            mem_req <= 1'b0;
          end
        end
        HOLD: begin
          if (stall == StallNo) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    if_inst         = NOP_INST;
    fetch_stall_req = 1'b0;
    unique case (state)
      REQ: begin
        if_inst         = mem_ack ? mem_rdata : NOP_INST;
        fetch_stall_req = !mem_ack;
      end
      HOLD:    if_inst = ibuf;
      default: if_inst = NOP_INST;
    endcase
  end

  assign mem_addr = pc;
  assign if_pc    = pc;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table for the documented scenarios,
// then randomized traffic checked against a queue-based behavioural model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [15:0] branch_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        fetch_stall_req;
  logic [15:0] if_pc;
  logic [15:0] if_inst;

  int test_cnt = 0;
  int fail_cnt = 0;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag     (branch_flag),
    .branch_target   (branch_target),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .fetch_stall_req (fetch_stall_req),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        chk;
    logic        req;
    logic [15:0] addr;
    logic [15:0] inst;
    logic        fsr;
  } vec_t;

  function automatic vec_t mkv(logic r, logic s, logic b, logic [15:0] t, logic a,
                               logic [15:0] d, logic c, logic q, logic [15:0] ad,
                               logic [15:0] in, logic f);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.ack = a; v.rdata = d;
    v.chk = c; v.req = q; v.addr = ad; v.inst = in; v.fsr = f;
    return v;
  endfunction

  // Behavioural model: a "fresh" cycle after reset issues nothing, a queue
  // holds an instruction captured during a stall, otherwise memory is read.
  logic        m_known = 1'b0;
  logic        m_fresh;
  logic [15:0] m_pc;
  logic [15:0] m_buf[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_expect(output logic req, output logic [15:0] inst, output logic fsr);
    if (m_fresh) begin
      req = 1'b0; inst = 16'h0800; fsr = 1'b0;
    end else if (m_buf.size() > 0) begin
      req = 1'b0; inst = m_buf[0]; fsr = 1'b0;
    end else begin
      req = 1'b1; inst = mem_ack ? mem_rdata : 16'h0800; fsr = !mem_ack;
    end
  endtask

  function automatic logic [15:0] model_next(logic [15:0] pc);
    return branch_flag ? branch_target : pc + 16'd1;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_known = 1'b1;
      m_fresh = 1'b1;
      m_pc    = 16'h0000;
      m_buf.delete();
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (m_buf.size() > 0) begin
      if (!stall) begin
        void'(m_buf.pop_front());
        m_pc = model_next(m_pc);
      end
    end else if (mem_ack) begin
      if (stall) m_buf.push_back(mem_rdata);
      else       m_pc = model_next(m_pc);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [15:0] t,
                       input logic a, input logic [15:0] d);
    rst = r; stall = s; branch_flag = b; branch_target = t; mem_ack = a; mem_rdata = d;
  endtask

  vec_t vecs[$];

  initial begin
    logic        e_req;
    logic [15:0] e_inst;
    logic        e_fsr;
    logic [31:0] rnd;
    logic [31:0] rnd2;

    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

    //            rst stall br tgt      ack rdata    chk req addr     inst     fsr
    vecs.push_back(mkv(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0800, 0));
    vecs.push_back(mkv(1, 0, 0, 16'h0000, 1, 16'h7777, 1, 0, 16'h0000, 16'h0800, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h7777, 1, 0, 16'h0000, 16'h0800, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h0100, 1, 1, 16'h0000, 16'h0100, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h0101, 1, 1, 16'h0001, 16'h0101, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h0102, 1, 1, 16'h0002, 16'h0102, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 0, 16'h0103, 1, 1, 16'h0003, 16'h0800, 1));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 0, 16'h0103, 1, 1, 16'h0003, 16'h0800, 1));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h0103, 1, 1, 16'h0003, 16'h0103, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h0104, 1, 1, 16'h0004, 16'h0104, 0));
    vecs.push_back(mkv(0, 1, 0, 16'h0000, 1, 16'hABCD, 1, 1, 16'h0005, 16'hABCD, 0));
    vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0005, 16'hABCD, 0));
    vecs.push_back(mkv(0, 1, 0, 16'h0000, 1, 16'h1111, 1, 0, 16'h0005, 16'hABCD, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h2222, 1, 0, 16'h0005, 16'hABCD, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h0106, 1, 1, 16'h0006, 16'h0106, 0));
    vecs.push_back(mkv(0, 0, 1, 16'h0040, 1, 16'h0107, 1, 1, 16'h0007, 16'h0107, 0));
    vecs.push_back(mkv(0, 0, 1, 16'h0007, 1, 16'h0140, 1, 1, 16'h0040, 16'h0140, 0));
    vecs.push_back(mkv(0, 1, 1, 16'h0040, 1, 16'h0207, 1, 1, 16'h0007, 16'h0207, 0));
    vecs.push_back(mkv(0, 1, 1, 16'h0040, 0, 16'h0000, 1, 0, 16'h0007, 16'h0207, 0));
    vecs.push_back(mkv(0, 0, 1, 16'h0040, 0, 16'h0000, 1, 0, 16'h0007, 16'h0207, 0));
    vecs.push_back(mkv(0, 0, 1, 16'hFFFF, 1, 16'h0240, 1, 1, 16'h0040, 16'h0240, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'hFFAA, 1, 1, 16'hFFFF, 16'hFFAA, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h0300, 1, 1, 16'h0000, 16'h0300, 0));
    vecs.push_back(mkv(1, 0, 0, 16'h0000, 1, 16'h5555, 1, 1, 16'h0001, 16'h5555, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 16'h5555, 1, 0, 16'h0000, 16'h0800, 0));
    vecs.push_back(mkv(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'h0800, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
      #4;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d mem_req", i), {15'd0, mem_req}, {15'd0, vecs[i].req});
        check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
        check($sformatf("vec%0d if_pc", i), if_pc, vecs[i].addr);
        check($sformatf("vec%0d if_inst", i), if_inst, vecs[i].inst);
        check($sformatf("vec%0d fetch_stall_req", i), {15'd0, fetch_stall_req}, {15'd0, vecs[i].fsr});
      end
      @(posedge clk);
      model_update();
      #1;
    end

    // Randomized traffic; the model has tracked the table and is in sync.
    for (int n = 0; n < 3000; n++) begin
      rnd  = $urandom;
      rnd2 = $urandom;
      drive((rnd[9:0] < 10'd8), (rnd[12:11] == 2'b00), (rnd[15:13] == 3'b000),
            rnd2[15:0], (rnd[18:16] < 3'd5), rnd2[31:16]);
      #4;
      if (m_known) begin
        model_expect(e_req, e_inst, e_fsr);
        check("rnd mem_req", {15'd0, mem_req}, {15'd0, e_req});
        check("rnd mem_addr", mem_addr, m_pc);
        check("rnd if_pc", if_pc, m_pc);
        check("rnd if_inst", if_inst, e_inst);
        check("rnd fetch_stall_req", {15'd0, fetch_stall_req}, {15'd0, e_fsr});
      end
      @(posedge clk);
      model_update();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage for the 16-bit pipelined CPU: owns the PC, issues instruction reads to the instruction-memory port with a req/ack handshake, and drives `if_pc`/`if_inst` into the IF/ID pipeline register. Absorbs memory wait states by requesting a pipeline stall. Buffers an instruction that arrives while the pipeline is stalled so it is never refetched. Applies branch targets from ID with delay-slot semantics.

## Interface
- `PC_RESET`, 16'h0000, PC value after reset.
- `NOP_INST`, 16'h0800, bubble instruction presented when no valid instruction exists.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high (`RstEnable`).
- `stall`  in  1  IF hold from stall controller (`StallYes` = hold).
- `branch_flag`  in  1  ID resolved a taken branch/jump.
- `branch_target`  in  16  target address, valid with `branch_flag`.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  16  read address, always equal to PC.
- `mem_ack`  in  1  read data valid this cycle; may be low for any number of cycles.
- `mem_rdata`  in  16  instruction word, valid when `mem_ack`=1.
- `fetch_stall_req`  out  1  request to stall pipeline (outstanding fetch).
- `if_pc`  out  16  PC of presented instruction, to IF/ID.
- `if_inst`  out  16  presented instruction, to IF/ID.

## Operation
- Registers: `pc`[15:0], `ibuf`[15:0], `state` ∈ {IDLE, REQ, HOLD}.
- Reset (`rst`=1 at edge, overrides all else): `pc`←PC_RESET, `ibuf`←NOP_INST, `state`←IDLE. Any `mem_ack` in that cycle is discarded.
- IDLE: `mem_req`=0, `if_inst`=NOP_INST, `fetch_stall_req`=0. Next state REQ unconditionally.
- REQ: `mem_req`=1.
  - `mem_ack`=0: `if_inst`=NOP_INST, `fetch_stall_req`=1, stay REQ, `pc` unchanged.
  - `mem_ack`=1: `if_inst`=`mem_rdata` (combinational), `fetch_stall_req`=0.
    - `stall`=0: advance.
    - `stall`=1: `ibuf`←`mem_rdata`, go HOLD.
- HOLD: `mem_req`=0, `if_inst`=`ibuf`, `fetch_stall_req`=0.
  - `stall`=1: stay HOLD.
  - `stall`=0: advance.
- Advance: `pc`←`branch_flag` ? `branch_target` : `pc`+1, state←REQ. `branch_flag` is sampled only on an advance edge; ignored otherwise. The instruction in IF when a branch is in ID is the delay slot and is always delivered.
- `if_pc`=`pc` and `mem_addr`=`pc` in all states.
- `pc`+1 is modulo 2^16: 16'hFFFF advances to 16'h0000.

## Timing
- Outputs after reset edge: `mem_req`=0, `mem_addr`=`if_pc`=PC_RESET, `if_inst`=NOP_INST, `fetch_stall_req`=0.
- Memory → `if_inst` path is combinational; the IF/ID register captures it on the same edge the PC advances.
- Zero-wait memory (`mem_ack` tied high): one instruction per cycle, `fetch_stall_req` never asserted.
- N wait cycles: `fetch_stall_req` high for exactly N cycles, and `mem_addr` stable throughout.
- `mem_ack` while stalled: memory is released on the next cycle (HOLD drops `mem_req`). Delivery resumes on the first cycle with `stall`=0.
- Simultaneous `stall`=1 and `branch_flag`=1: no PC change.

## Structure
- Shared defines: `RstEnable`/`RstDisable`, `StallYes`/`StallNo`, NOP_INST value, 16-bit word/address widths, IDLE/REQ/HOLD encodings.
- One natural sub-module: `pc_reg`. It holds `pc`, takes reset, advance, `branch_flag` and `branch_target`, and implements the next-PC mux and wrap.

## Test plan
- Reset: `rst`=1 for 2 cycles, then 0. Cycle 1 after release: `mem_req`=0, `if_inst`=16'h0800. Cycle 2: `mem_req`=1, `mem_addr`=0.
- Zero-wait: `mem_ack`=1, `mem_rdata`=16'h0100+addr. Consecutive cycles present `if_pc` 0,1,2 with `if_inst` 16'h0100, 16'h0101, 16'h0102, and `fetch_stall_req`=0 throughout.
- Wait states: at `pc`=3, `mem_ack` is low 2 cycles. `fetch_stall_req`=1 and `if_inst`=16'h0800 for 2 cycles, with `mem_addr`=3 held. On the ack cycle `if_inst`=`mem_rdata`; next `pc`=4.
- Stall on ack: at `pc`=5, `mem_rdata`=16'hABCD with `stall`=1 for 3 cycles. `mem_req`=0 and `if_inst`=16'hABCD while stalled. When stall drops, `pc`→6 and no refetch of address 5.
- Branch: at `pc`=7, valid fetch with `branch_flag`=1, target 16'h0040: next `mem_addr`=16'h0040. Repeat with `stall`=1: `pc` stays 7 until stall drops.
- Wrap/reset: advance from `pc`=16'hFFFF gives `pc`=0. Assert `rst` in REQ with `mem_ack`=1: the instruction is not presented after reset, and `pc`=PC_RESET.
